// File: rtl/crack_pkg.sv
// rtl/crack_pkg.sv - shared states, charset codes, widths and guess-entry type for the crack job controller
package crack_pkg;

    localparam int GUESS_W = 128;
    localparam int LEN_W   = 5;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_RUN       = 3'd2;
    localparam logic [2:0] ST_DRAIN     = 3'd3;
    localparam logic [2:0] ST_FOUND     = 3'd4;
    localparam logic [2:0] ST_EXHAUSTED = 3'd5;
    localparam logic [2:0] ST_ERROR     = 3'd6;

    typedef enum logic [2:0] {
        CS_LOWER = 3'd0,
        CS_UPPER = 3'd1,
        CS_DIGIT = 3'd2,
        CS_ALNUM = 3'd3,
        CS_PRINT = 3'd4
    } charset_e;

    typedef struct packed {
        logic               valid;
        logic [LEN_W-1:0]   len;
        logic [GUESS_W-1:0] guess;
    } guess_entry_t;

    // A length range is unusable if it is empty, starts at zero or exceeds the guess bus
    function automatic logic cfg_bad(input logic [LEN_W-1:0] mn, input logic [LEN_W-1:0] mx,
                                     input int max_guess_len);
        return (mn == '0) || (mn > mx) || (int'(mx) > max_guess_len);
    endfunction

endpackage

// File: rtl/crack_guess_delay.sv
// rtl/crack_guess_delay.sv - fixed-depth delay line pairing each issued guess with its late hash result
module crack_guess_delay
    import crack_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  guess_entry_t push,
    output guess_entry_t tail
);

    guess_entry_t line [DEPTH];

    // Shift one entry per cycle; flush invalidates everything still in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) line[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) line[i] <= '0;
        end else begin
            line[0] <= push;
            for (int i = 1; i < DEPTH; i++) line[i] <= line[i-1];
        end
    end

    assign tail = line[DEPTH-1];

endmodule

// File: rtl/crack_job_controller.sv
// rtl/crack_job_controller.sv - sequences a guess generator over a length range; CRACK_CTRL_PERF_EN adds counters
module crack_job_controller
    import crack_pkg::*;
#(
    parameter int HASH_LAT      = 4,
    parameter int COUNT_W       = 48,
    parameter int MAX_GUESS_LEN = 16
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [2:0]         charset_in,
    input  logic [4:0]         min_len,
    input  logic [4:0]         max_len,
    output logic               gen_reset,
    output logic [2:0]         gen_charset,
    output logic [4:0]         gen_guesslen,
    input  logic [127:0]       gen_guess,
    input  logic               gen_done,
    output logic               hash_valid,
    output logic [127:0]       hash_guess,
    input  logic               hash_hit,
    output logic               busy,
    output logic               found,
    output logic [127:0]       found_guess,
    output logic [4:0]         found_len,
    output logic               exhausted,
    output logic               cfg_error,
`ifdef CRACK_CTRL_PERF_EN
    output logic [COUNT_W-1:0] guess_count,
    output logic [COUNT_W-1:0] run_cycles
`else
    output logic [COUNT_W-1:0] guess_count
`endif
);

    logic [2:0]   state;
    logic [2:0]   cfg_charset;
    logic [4:0]   cur_len;
    logic [4:0]   max_len_q;
    logic [5:0]   drain_cnt;
    logic         idle_or_term;
    logic         bad_cfg;
    logic         start_accept;
    logic         hit_take;
    guess_entry_t push;
    guess_entry_t tail;

    assign idle_or_term = (state == ST_IDLE) || (state == ST_FOUND) ||
                          (state == ST_EXHAUSTED) || (state == ST_ERROR);
    assign bad_cfg      = cfg_bad(min_len, max_len, MAX_GUESS_LEN);
    assign start_accept = start && !abort && idle_or_term && !bad_cfg;
    assign hit_take     = hash_hit && tail.valid;

    assign busy         = (state == ST_LOAD) || (state == ST_RUN) || (state == ST_DRAIN);
    assign hash_valid   = (state == ST_RUN);
    assign hash_guess   = hash_valid ? gen_guess : '0;
    assign gen_reset    = (state == ST_LOAD) || (state == ST_FOUND) ||
                          (state == ST_EXHAUSTED) || (state == ST_ERROR);
    assign gen_charset  = cfg_charset;
    assign gen_guesslen = cur_len;

    assign push = '{valid: hash_valid, len: cur_len, guess: gen_guess};

    crack_guess_delay #(.DEPTH(HASH_LAT)) u_delay (
        .clk   (clk),
        .rst   (reset),
        .flush (start_accept || abort),
        .push  (push),
        .tail  (tail)
    );

    // Job FSM: a hit against a valid tail outranks length stepping and drain completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cfg_charset <= '0;
            cur_len     <= '0;
            max_len_q   <= '0;
            drain_cnt   <= '0;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            cfg_error   <= 1'b0;
            found_guess <= '0;
            found_len   <= '0;
        end else if (abort) begin
            state     <= ST_IDLE;
            found     <= 1'b0;
            exhausted <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_FOUND, ST_EXHAUSTED, ST_ERROR: begin
                    if (start) begin
                        found     <= 1'b0;
                        exhausted <= 1'b0;
                        if (bad_cfg) begin
                            cfg_error <= 1'b1;
                            state     <= ST_ERROR;
                        end else begin
                            cfg_error   <= 1'b0;
                            cfg_charset <= charset_in;
                            cur_len     <= min_len;
                            max_len_q   <= max_len;
                            state       <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD, ST_RUN, ST_DRAIN: begin
                    if (hit_take) begin
                        found       <= 1'b1;
                        found_guess <= tail.guess;
                        found_len   <= tail.len;
                        state       <= ST_FOUND;
                    end else if (state == ST_LOAD) begin
                        state <= ST_RUN;
                    end else if (state == ST_RUN) begin
                        if (gen_done) begin
                            if (cur_len == max_len_q) begin
                                drain_cnt <= '0;
                                state     <= ST_DRAIN;
                            end else begin
                                cur_len <= cur_len + 5'd1;
                                state   <= ST_LOAD;
                            end
                        end
                    end else if (drain_cnt == 6'(HASH_LAT - 1)) begin
                        exhausted <= 1'b1;
                        state     <= ST_EXHAUSTED;
                    end else begin
                        drain_cnt <= drain_cnt + 6'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef CRACK_CTRL_PERF_EN
    // Saturating per-job guess and busy-cycle counters, cleared by an accepted start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            guess_count <= '0;
            run_cycles  <= '0;
        end else if (start_accept) begin
            guess_count <= '0;
            run_cycles  <= '0;
        end else begin
            if (hash_valid && !(&guess_count)) guess_count <= guess_count + 1'b1;
            if (busy && !(&run_cycles))        run_cycles  <= run_cycles + 1'b1;
        end
    end
`else
    assign guess_count = '0;
`endif

endmodule
